// File: rtl/inreq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// inreq_ctrl_pkg
// Shared router definitions for the input-port request controller: port
// widths, the reset active level, flit-type codes, multicast-table status
// codes and the controller state type.
// Ports: none (package only).
// -----------------------------------------------------------------------------
package inreq_ctrl_pkg;

   localparam int PORTW   = 2;
   localparam int PORT    = 4;
   localparam int DSTATUS = 1;

   localparam int NPORT = PORT + 1;
   localparam int NIDX  = PORTW + 1;

   localparam logic Enable_ = 1'b0;

   localparam logic [1:0] FT_HEAD   = 2'b00;
   localparam logic [1:0] FT_BODY   = 2'b01;
   localparam logic [1:0] FT_TAIL   = 2'b10;
   localparam logic [1:0] FT_SINGLE = 2'b11;

   localparam logic [DSTATUS:0] MT_NONE  = '0;
   localparam logic [DSTATUS:0] MT_UNI   = 2'b01;
   localparam logic [DSTATUS:0] MT_MULTI = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UREQ,
      S_USEND,
      S_MREQ,
      S_MSEND
   } state_t;

endpackage

// File: rtl/inreq_ctrl_lsb_enc.sv
// -----------------------------------------------------------------------------
// lsb_enc
// Picks the lowest set bit of a destination mask and counts its set bits.
// Ports:
//   i_mask  - destination bitmap, one bit per output port
//   o_idx   - index of the lowest set bit (0 when the mask is empty)
//   o_count - number of set bits in the mask
// -----------------------------------------------------------------------------
module lsb_enc
   import inreq_ctrl_pkg::*;
(
   input  logic [PORT:0]  i_mask,
   output logic [PORTW:0] o_idx,
   output logic [PORT:0]  o_count
);

   // Scan from the top down so the last hit written is the lowest set bit;
   // that is the next multicast destination to be served.
   always_comb begin
      o_idx = '0;
      for (int j = PORT; j >= 0; j--) begin
         if (i_mask[j]) begin
            o_idx = NIDX'(j);
         end
      end
   end

   // Plain population count, reported as the number of destinations that
   // are still waiting for their copy of the flit.
   always_comb begin
      o_count = '0;
      for (int j = 0; j <= PORT; j++) begin
         o_count = o_count + NPORT'(i_mask[j]);
      end
   end

endmodule

// File: rtl/inreq_ctrl.sv
// -----------------------------------------------------------------------------
// inreq_ctrl
// Input-port request controller: turns the flit at the head of this input's
// buffer into requests to output-port arbiters, sends unicast packets as
// wormholes and replicates single-flit multicasts one destination at a time.
// Ports:
//   clk, rst_           - clock, asynchronous active-low reset
//   buf_empty/buf_ftype - input buffer head status and flit type
//   rc_port/rc_mcast/rc_mdst - route-compute result for a head/single flit
//   grt, out_rdy        - per-output grant to this input, per-output ready
//   port, req           - requested output port and request strobe
//   multab, multab_ct   - multicast entry status and outstanding count
//   deq, xfer, err      - buffer pop, crossbar transfer, protocol error
// -----------------------------------------------------------------------------
module inreq_ctrl
   import inreq_ctrl_pkg::*;
#(
   parameter int PORTID = 0
)
(
   input  logic             clk,
   input  logic             rst_,
   input  logic             buf_empty,
   input  logic [1:0]       buf_ftype,
   input  logic [PORTW:0]   rc_port,
   input  logic             rc_mcast,
   input  logic [PORT:0]    rc_mdst,
   input  logic [PORT:0]    grt,
   input  logic [PORT:0]    out_rdy,
   output logic [PORTW:0]   port,
   output logic             req,
   output logic [DSTATUS:0] multab,
   output logic [PORT:0]    multab_ct,
   output logic             deq,
   output logic             xfer,
   output logic             err
);

   localparam logic [PORT:0] SELF_BIT = NPORT'(1) << PORTID;

   state_t         r_state;
   logic [PORTW:0] r_port;
   logic [PORT:0]  r_mask;
   logic           r_live;

   logic [PORTW:0] w_lsbIdx;
   logic [PORT:0]  w_popCnt;
   logic           w_inMcast;
   logic [PORTW:0] w_selPort;
   logic [PORT:0]  w_selBit;
   logic           w_grtSel;
   logic           w_rdySel;
   logic [PORT:0]  w_newMask;
   logic [PORT:0]  w_mcRemain;
   logic           w_idleAct;
   logic           w_badHead;
   logic           w_lastFlit;
   logic           w_uXfer;
   logic           w_mXfer;

   lsb_enc u_lsbEnc (
      .i_mask  (r_mask),
      .o_idx   (w_lsbIdx),
      .o_count (w_popCnt)
   );

   // While multicasting, the port being served is always the lowest bit
   // still set in the mask; otherwise it is the latched unicast port.
   assign w_inMcast  = (r_state == S_MREQ) || (r_state == S_MSEND);
   assign w_selPort  = w_inMcast ? w_lsbIdx : r_port;
   assign w_selBit   = NPORT'(1) << w_selPort;
   assign w_grtSel   = |(grt & w_selBit);
   assign w_rdySel   = |(out_rdy & w_selBit);

   // A multicast never loops back to its own input, and a destination is
   // retired from the mask as soon as its copy crosses the crossbar.
   assign w_newMask  = rc_mdst & ~SELF_BIT;
   assign w_mcRemain = r_mask & ~(NPORT'(1) << w_lsbIdx);

   // r_live stays low for the first edge after reset so a head flit that
   // is already waiting cannot be acted on until the second edge.
   assign w_idleAct  = r_live && (r_state == S_IDLE) && !buf_empty;
   assign w_badHead  = (buf_ftype == FT_BODY) || (buf_ftype == FT_TAIL) ||
                       ((buf_ftype == FT_HEAD) && rc_mcast);
   assign w_lastFlit = (buf_ftype == FT_TAIL) || (buf_ftype == FT_SINGLE);
   assign w_uXfer    = !buf_empty && w_rdySel;
   assign w_mXfer    = w_rdySel;

   // Output decode from the registered state and mask/port. Only the
   // transfer strobes and the idle-state drop/error look at live inputs,
   // because they must act in the same cycle the buffer head is valid.
   always_comb begin
      port      = r_port;
      req       = 1'b0;
      multab    = MT_NONE;
      multab_ct = '0;
      deq       = 1'b0;
      xfer      = 1'b0;
      err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            err = w_idleAct && w_badHead;
            deq = w_idleAct && (w_badHead ||
                  ((buf_ftype == FT_SINGLE) && rc_mcast && (w_newMask == '0)));
         end
         S_UREQ: begin
            req    = 1'b1;
            multab = MT_UNI;
         end
         S_USEND: begin
            req    = 1'b1;
            multab = MT_UNI;
            xfer   = w_uXfer;
            deq    = w_uXfer;
         end
         S_MREQ: begin
            port      = w_lsbIdx;
            req       = 1'b1;
            multab    = MT_MULTI;
            multab_ct = w_popCnt;
         end
         S_MSEND: begin
            port      = w_lsbIdx;
            req       = 1'b1;
            multab    = MT_MULTI;
            multab_ct = w_popCnt;
            xfer      = w_mXfer;
            deq       = w_mXfer && (w_mcRemain == '0);
         end
         default: begin
         end
      endcase
   end

   // Controller state machine. Unicast packets hold the output from grant
   // until their tail leaves; a multicast re-arbitrates for each remaining
   // destination and pops the buffer only with its last copy.
   always_ff @(posedge clk or negedge rst_) begin
      if (rst_ == Enable_) begin
         r_state <= S_IDLE;
         r_port  <= '0;
         r_mask  <= '0;
         r_live  <= 1'b0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_idleAct && !w_badHead) begin
                  if (rc_mcast) begin
                     r_mask <= w_newMask;
                     if (w_newMask != '0) begin
                        r_state <= S_MREQ;
                     end
                  end else begin
                     r_port  <= rc_port;
                     r_state <= S_UREQ;
                  end
               end
            end
            S_UREQ: begin
               if (w_grtSel) begin
                  r_state <= S_USEND;
               end
            end
            S_USEND: begin
               if (w_uXfer && w_lastFlit) begin
                  r_state <= S_IDLE;
               end
            end
            S_MREQ: begin
               if (w_grtSel) begin
                  r_state <= S_MSEND;
               end
            end
            S_MSEND: begin
               if (w_mXfer) begin
                  r_mask <= w_mcRemain;
                  if (w_mcRemain == '0) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_MREQ;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inreq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inreq_ctrl
// Self-checking bench for inreq_ctrl: directed cycle tables for unicast,
// stalled unicast, multicast, drop/error and reset cases, followed by a
// randomized run against a destination-queue model of the controller.
// -----------------------------------------------------------------------------
module tb_inreq_ctrl;
   import inreq_ctrl_pkg::*;

   typedef struct {
      logic             empty;
      logic [1:0]       ftype;
      logic [PORTW:0]   rcPort;
      logic             mcast;
      logic [PORT:0]    mdst;
      logic [PORT:0]    grt;
      logic [PORT:0]    rdy;
      logic             eReq;
      logic [PORTW:0]   ePort;
      logic             eXfer;
      logic             eDeq;
      logic             eErr;
      logic             chkMt;
      logic [DSTATUS:0] eMultab;
      logic [PORT:0]    eCt;
   } vecT;

   localparam logic [PORT:0] ALL = '1;

   logic             clk;
   logic             rst_;
   logic             bufEmpty;
   logic [1:0]       bufFtype;
   logic [PORTW:0]   rcPort;
   logic             rcMcast;
   logic [PORT:0]    rcMdst;
   logic [PORT:0]    grt;
   logic [PORT:0]    outRdy;

   logic [PORTW:0]   d0Port, d1Port;
   logic             d0Req, d1Req;
   logic [DSTATUS:0] d0Multab, d1Multab;
   logic [PORT:0]    d0Ct, d1Ct;
   logic             d0Deq, d1Deq;
   logic             d0Xfer, d1Xfer;
   logic             d0Err, d1Err;

   int total;
   int bad;
   int deqCount;

   vecT uniTab[8];
   vecT mcTab[9];

   int  mq[$];
   int  startList[$];
   bit  mIsM;
   bit  mGrant;
   bit  regen;

   inreq_ctrl #(.PORTID(0)) dut0 (
      .clk(clk), .rst_(rst_), .buf_empty(bufEmpty), .buf_ftype(bufFtype),
      .rc_port(rcPort), .rc_mcast(rcMcast), .rc_mdst(rcMdst), .grt(grt),
      .out_rdy(outRdy), .port(d0Port), .req(d0Req), .multab(d0Multab),
      .multab_ct(d0Ct), .deq(d0Deq), .xfer(d0Xfer), .err(d0Err)
   );

   inreq_ctrl #(.PORTID(1)) dut1 (
      .clk(clk), .rst_(rst_), .buf_empty(bufEmpty), .buf_ftype(bufFtype),
      .rc_port(rcPort), .rc_mcast(rcMcast), .rc_mdst(rcMdst), .grt(grt),
      .out_rdy(outRdy), .port(d1Port), .req(d1Req), .multab(d1Multab),
      .multab_ct(d1Ct), .deq(d1Deq), .xfer(d1Xfer), .err(d1Err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so a broken design can never hang the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vecT mk(
      input logic e, input logic [1:0] ft, input logic [PORTW:0] rp,
      input logic mc, input logic [PORT:0] md, input logic [PORT:0] g,
      input logic [PORT:0] r, input logic eReq, input logic [PORTW:0] ePort,
      input logic eXfer, input logic eDeq, input logic eErr, input logic chkMt,
      input logic [DSTATUS:0] eMt, input logic [PORT:0] eCt);
      vecT v;
      v.empty = e;    v.ftype = ft;   v.rcPort = rp;  v.mcast = mc;
      v.mdst = md;    v.grt = g;      v.rdy = r;
      v.eReq = eReq;  v.ePort = ePort; v.eXfer = eXfer; v.eDeq = eDeq;
      v.eErr = eErr;  v.chkMt = chkMt; v.eMultab = eMt; v.eCt = eCt;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vecT v);
      bufEmpty = v.empty;
      bufFtype = v.ftype;
      rcPort   = v.rcPort;
      rcMcast  = v.mcast;
      rcMdst   = v.mdst;
      grt      = v.grt;
      outRdy   = v.rdy;
   endtask

   task automatic checkOutput(input vecT v, input string name, input int which);
      logic             aReq, aXfer, aDeq, aErr;
      logic [PORTW:0]   aPort;
      logic [DSTATUS:0] aMt;
      logic [PORT:0]    aCt;
      if (which == 0) begin
         aReq = d0Req; aXfer = d0Xfer; aDeq = d0Deq; aErr = d0Err;
         aPort = d0Port; aMt = d0Multab; aCt = d0Ct;
      end else begin
         aReq = d1Req; aXfer = d1Xfer; aDeq = d1Deq; aErr = d1Err;
         aPort = d1Port; aMt = d1Multab; aCt = d1Ct;
      end
      deqCount += int'(aDeq);
      cmp({name, ".req"}, 32'(aReq), 32'(v.eReq));
      if (v.eReq) cmp({name, ".port"}, 32'(aPort), 32'(v.ePort));
      cmp({name, ".xfer"}, 32'(aXfer), 32'(v.eXfer));
      cmp({name, ".deq"}, 32'(aDeq), 32'(v.eDeq));
      cmp({name, ".err"}, 32'(aErr), 32'(v.eErr));
      if (v.chkMt) begin
         cmp({name, ".multab"}, 32'(aMt), 32'(v.eMultab));
         cmp({name, ".multab_ct"}, 32'(aCt), 32'(v.eCt));
      end
   endtask

   task automatic checkZero(input string name, input int which);
      vecT z;
      z = mk(1'b1, FT_HEAD, '0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0,
             1'b1, MT_NONE, '0);
      checkOutput(z, name, which);
      cmp({name, ".portzero"}, 32'(which == 0 ? d0Port : d1Port), 32'd0);
   endtask

   task automatic runRow(input vecT v, input string name, input int which);
      applyStimulus(v);
      @(negedge clk);
      checkOutput(v, name, which);
      @(posedge clk);
      #1;
   endtask

   // Holds reset for two edges, releases just after an edge, then lets the
   // one start-up edge pass so the caller begins on the first active cycle.
   task automatic resetDut();
      rst_ = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_ = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic newHead();
      bufEmpty = ($urandom % 4) == 0;
      bufFtype = 2'($urandom);
      rcPort   = NIDX'($urandom % NPORT);
      rcMcast  = ($urandom % 3) == 0;
      rcMdst   = NPORT'($urandom);
   endtask

   // Reference model: the controller owes a list of destinations for the
   // current head flit. Idle means the list is empty; the front entry is
   // requested until granted, then served until the flit(s) leave.
   task automatic modelCycle(input int cyc);
      vecT v;
      int  d;
      bit  startM;
      d = 0;
      startM = 1'b0;
      startList.delete();
      v = mk(1'b0, FT_HEAD, '0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0,
             1'b1, MT_NONE, '0);
      if (mq.size() == 0) begin
         if (!bufEmpty) begin
            if (bufFtype == FT_BODY || bufFtype == FT_TAIL ||
                (bufFtype == FT_HEAD && rcMcast)) begin
               v.eDeq = 1'b1;
               v.eErr = 1'b1;
            end else if (rcMcast) begin
               for (int j = 0; j <= PORT; j++) begin
                  if (rcMdst[j] && j != 0) startList.push_back(j);
               end
               if (startList.size() == 0) v.eDeq = 1'b1;
               startM = 1'b1;
            end else begin
               startList.push_back(int'(rcPort));
            end
         end
      end else begin
         d = mq[0];
         v.eReq  = 1'b1;
         v.ePort = NIDX'(d);
         if (!mGrant) begin
            v.eMultab = mIsM ? MT_MULTI : MT_UNI;
            v.eCt     = mIsM ? NPORT'(mq.size()) : '0;
         end else begin
            v.chkMt = 1'b0;
            if (mIsM) begin
               v.eXfer = outRdy[d];
               v.eDeq  = outRdy[d] && mq.size() == 1;
            end else begin
               v.eXfer = !bufEmpty && outRdy[d];
               v.eDeq  = v.eXfer;
            end
         end
      end
      @(negedge clk);
      checkOutput(v, $sformatf("rnd.c%0d", cyc), 0);
      if (mq.size() == 0) begin
         if (startList.size() > 0) begin
            mq = startList;
            mIsM = startM;
            mGrant = 1'b0;
         end
      end else if (!mGrant) begin
         mGrant = grt[d];
      end else if (v.eXfer && (mIsM || bufFtype == FT_TAIL || bufFtype == FT_SINGLE)) begin
         void'(mq.pop_front());
         mGrant = 1'b0;
      end
      regen = v.eDeq || bufEmpty;
   endtask

   // Main sequence: directed tables first, then the randomized run.
   initial begin
      total = 0;
      bad = 0;
      deqCount = 0;

      uniTab[0] = mk(0, FT_HEAD, 2, 0, 0, 5'b00100, ALL, 0, 0, 0, 0, 0, 1, MT_NONE, 0);
      uniTab[1] = mk(0, FT_HEAD, 2, 0, 0, 5'b00000, ALL, 1, 2, 0, 0, 0, 1, MT_UNI, 0);
      uniTab[2] = mk(0, FT_HEAD, 2, 0, 0, 5'b00010, ALL, 1, 2, 0, 0, 0, 1, MT_UNI, 0);
      uniTab[3] = mk(0, FT_HEAD, 2, 0, 0, 5'b00100, ALL, 1, 2, 0, 0, 0, 1, MT_UNI, 0);
      uniTab[4] = mk(0, FT_HEAD, 2, 0, 0, 5'b00000, ALL, 1, 2, 1, 1, 0, 0, MT_NONE, 0);
      uniTab[5] = mk(0, FT_BODY, 2, 0, 0, 5'b00000, ALL, 1, 2, 1, 1, 0, 0, MT_NONE, 0);
      uniTab[6] = mk(0, FT_TAIL, 2, 0, 0, 5'b00000, ALL, 1, 2, 1, 1, 0, 0, MT_NONE, 0);
      uniTab[7] = mk(1, FT_HEAD, 2, 0, 0, 5'b00000, ALL, 0, 0, 0, 0, 0, 1, MT_NONE, 0);

      mcTab[0] = mk(0, FT_SINGLE, 0, 1, 5'b10110, 5'b00000, ALL,      0, 0, 0, 0, 0, 1, MT_NONE, 0);
      mcTab[1] = mk(0, FT_SINGLE, 0, 1, 5'b10110, 5'b00010, ALL,      1, 1, 0, 0, 0, 1, MT_MULTI, 3);
      mcTab[2] = mk(0, FT_SINGLE, 0, 1, 5'b10110, 5'b00000, ALL,      1, 1, 1, 0, 0, 0, MT_NONE, 0);
      mcTab[3] = mk(0, FT_SINGLE, 0, 1, 5'b10110, 5'b00100, ALL,      1, 2, 0, 0, 0, 1, MT_MULTI, 2);
      mcTab[4] = mk(0, FT_SINGLE, 0, 1, 5'b10110, 5'b00000, 5'b11011, 1, 2, 0, 0, 0, 0, MT_NONE, 0);
      mcTab[5] = mk(0, FT_SINGLE, 0, 1, 5'b10110, 5'b00000, ALL,      1, 2, 1, 0, 0, 0, MT_NONE, 0);
      mcTab[6] = mk(0, FT_SINGLE, 0, 1, 5'b10110, 5'b10000, ALL,      1, 4, 0, 0, 0, 1, MT_MULTI, 1);
      mcTab[7] = mk(0, FT_SINGLE, 0, 1, 5'b10110, 5'b00000, ALL,      1, 4, 1, 1, 0, 0, MT_NONE, 0);
      mcTab[8] = mk(1, FT_HEAD,   0, 0, 5'b00000, 5'b00000, ALL,      0, 0, 0, 0, 0, 1, MT_NONE, 0);

      rst_ = 1'b0;
      applyStimulus(mk(0, FT_BODY, 3, 0, 0, ALL, ALL, 0, 0, 0, 0, 0, 0, MT_NONE, 0));
      @(negedge clk);
      checkZero("reset.d0", 0);
      checkZero("reset.d1", 1);

      $display("[TB] unicast packet, steady ready");
      resetDut();
      for (int i = 0; i < 8; i++) runRow(uniTab[i], $sformatf("uni.c%0d", i), 0);

      $display("[TB] unicast packet with mid-body stall");
      resetDut();
      deqCount = 0;
      for (int i = 0; i < 5; i++) runRow(uniTab[i], $sformatf("stall.c%0d", i), 0);
      runRow(mk(0, FT_BODY, 2, 0, 0, 0, 5'b11011, 1, 2, 0, 0, 0, 0, MT_NONE, 0), "stall.rdy0a", 0);
      runRow(mk(0, FT_BODY, 2, 0, 0, 0, 5'b11011, 1, 2, 0, 0, 0, 0, MT_NONE, 0), "stall.rdy0b", 0);
      runRow(mk(1, FT_BODY, 2, 0, 0, 0, ALL,      1, 2, 0, 0, 0, 0, MT_NONE, 0), "stall.empty", 0);
      runRow(mk(0, FT_BODY, 2, 0, 0, 0, ALL,      1, 2, 1, 1, 0, 0, MT_NONE, 0), "stall.body", 0);
      runRow(mk(0, FT_TAIL, 2, 0, 0, 0, ALL,      1, 2, 1, 1, 0, 0, MT_NONE, 0), "stall.tail", 0);
      runRow(uniTab[7], "stall.idle", 0);
      cmp("stall.deqTotal", 32'(deqCount), 32'd3);

      $display("[TB] multicast to ports 1, 2, 4");
      resetDut();
      deqCount = 0;
      for (int i = 0; i < 9; i++) runRow(mcTab[i], $sformatf("mc.c%0d", i), 0);
      cmp("mc.deqTotal", 32'(deqCount), 32'd1);

      $display("[TB] multicast with no remote destination");
      resetDut();
      runRow(mk(0, FT_SINGLE, 0, 1, 5'b00010, 0, ALL, 0, 0, 0, 1, 0, 1, MT_NONE, 0), "mcself.p1", 1);
      runRow(mk(1, FT_HEAD, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 0, 1, MT_NONE, 0), "mcself.p1idle", 1);
      resetDut();
      runRow(mk(0, FT_SINGLE, 0, 1, 5'b00001, 0, ALL, 0, 0, 0, 1, 0, 1, MT_NONE, 0), "mcself.p0", 0);

      $display("[TB] illegal head flits");
      resetDut();
      runRow(mk(0, FT_BODY, 1, 0, 0, 0, ALL, 0, 0, 0, 1, 1, 1, MT_NONE, 0), "bad.body", 0);
      runRow(mk(0, FT_TAIL, 1, 0, 0, 0, ALL, 0, 0, 0, 1, 1, 1, MT_NONE, 0), "bad.tail", 0);
      runRow(mk(0, FT_HEAD, 1, 1, 5'b00110, 0, ALL, 0, 0, 0, 1, 1, 1, MT_NONE, 0), "bad.mchead", 0);
      runRow(mk(1, FT_HEAD, 1, 0, 0, 0, ALL, 0, 0, 0, 0, 0, 1, MT_NONE, 0), "bad.after", 0);

      $display("[TB] reset during unicast send");
      resetDut();
      for (int i = 0; i < 5; i++) runRow(uniTab[i], $sformatf("rstU.c%0d", i), 0);
      applyStimulus(uniTab[5]);
      @(negedge clk);
      checkOutput(uniTab[5], "rstU.before", 0);
      #1 rst_ = 1'b0;
      applyStimulus(uniTab[0]);
      #1;
      checkZero("rstU.during", 0);
      @(posedge clk);
      #1 rst_ = 1'b1;
      @(negedge clk);
      checkOutput(uniTab[0], "rstU.settle", 0);
      @(posedge clk);
      #1;
      runRow(uniTab[0], "rstU.c0", 0);
      runRow(uniTab[1], "rstU.c1", 0);

      $display("[TB] reset during multicast send");
      resetDut();
      runRow(mcTab[0], "rstM.c0", 0);
      runRow(mcTab[1], "rstM.c1", 0);
      applyStimulus(mcTab[2]);
      @(negedge clk);
      checkOutput(mcTab[2], "rstM.before", 0);
      #1 rst_ = 1'b0;
      #1;
      checkZero("rstM.during", 0);
      @(posedge clk);
      #1 rst_ = 1'b1;
      applyStimulus(mcTab[0]);
      @(negedge clk);
      checkOutput(mcTab[0], "rstM.settle", 0);
      @(posedge clk);
      #1;
      runRow(mcTab[0], "rstM.c0", 0);
      runRow(mcTab[1], "rstM.c1", 0);

      $display("[TB] randomized run");
      resetDut();
      mq.delete();
      mIsM = 1'b0;
      mGrant = 1'b0;
      regen = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (regen) newHead();
         grt = NPORT'($urandom);
         for (int j = 0; j <= PORT; j++) outRdy[j] = ($urandom % 4) != 0;
         modelCycle(cyc);
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inreq_ctrl.md
INREQ_CTRL -- requirements
Module: inreq_ctrl

Interface
REQ-001 PORTID, default 0, index of the input port this controller serves.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_  input  1  asynchronous, active-low reset (`Enable_ level).
REQ-004 buf_empty  input  1  input flit buffer has no head flit.
REQ-005 buf_ftype  input  2  head-flit type: 00 head, 01 body, 10 tail, 11 single.
REQ-006 rc_port  input  PORTW+1  unicast output port from route compute, valid when a head/single flit is at the buffer head.
REQ-007 rc_mcast  input  1  head/single flit is multicast.
REQ-008 rc_mdst  input  PORT+1  multicast destination bitmap.
REQ-009 grt  input  PORT+1  bit j is output-port arbiter j granting this input.
REQ-010 out_rdy  input  PORT+1  bit j is output port j able to accept one flit this cycle.
REQ-011 port  output  PORTW+1  requested output port number.
REQ-012 req  output  1  request to the arbiter selected by port.
REQ-013 multab  output  DSTATUS+1  bit1 is multicast request, bit0 is entry valid, other bits 0.
REQ-014 multab_ct  output  PORT+1  count of multicast destinations still outstanding.
REQ-015 deq  output  1  pop the buffer head this cycle.
REQ-016 xfer  output  1  head flit driven onto the crossbar this cycle.
REQ-017 err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-018 The FSM SHALL have states IDLE, UREQ, USEND, MREQ, MSEND; outputs derive from registered state and registered mask/port.
REQ-019 In IDLE with ~buf_empty and type head/single with ~rc_mcast: latch rc_port, go to UREQ.
REQ-020 In IDLE with ~buf_empty and type single with rc_mcast: latch mask = rc_mdst with bit PORTID cleared; mask nonzero -> MREQ; mask zero -> deq=1 for one cycle, stay IDLE.
REQ-021 In IDLE, head type body/tail, or head type with rc_mcast: deq=1 and err=1 for one cycle, stay IDLE.
REQ-022 UREQ: req=1, multab=01; grt[port]=1 at the edge -> USEND; otherwise hold.
REQ-023 USEND: req=1; in each cycle with ~buf_empty & out_rdy[port], xfer=1 and deq=1; when the flit transferred is tail or single -> IDLE (req=0 next cycle).
REQ-024 USEND with buf_empty or ~out_rdy[port]: no xfer/deq, req held, state held (wormhole stall).
REQ-025 MREQ: port = lowest set bit of mask, req=1, multab=11, multab_ct = popcount(mask); grt[port] -> MSEND.
REQ-026 MSEND: req=1; when out_rdy[port]: xfer=1, clear mask bit port; mask becomes zero -> deq=1, go to IDLE; otherwise go to MREQ.
REQ-027 A multicast flit SHALL be dequeued exactly once, in the cycle its last destination is transferred.
REQ-028 A grt bit other than grt[port], or any grt bit in IDLE, SHALL be ignored.
REQ-029 Outside UREQ/USEND/MREQ/MSEND: req=0, multab=0, multab_ct=0, xfer=0.
REQ-030 Latency: request one cycle after the head appears; first xfer no earlier than one cycle after grant.

Reset
REQ-031 Assertion of rst_ SHALL immediately force IDLE, mask=0, port=0, and all outputs 0, including mid-packet and mid-multicast.
REQ-032 After deassertion, the first request SHALL come no earlier than the second rising edge.

Structure
REQ-033 PORTW, PORT, DSTATUS, Enable_, and the flit-type codes SHALL come from the shared define header; no local redefinition.
REQ-034 The lowest-set-bit encoder plus popcount SHALL be one sub-module, lsb_enc.

Verification
REQ-035 Unicast 3-flit packet to port 2, grant at cycle 3, out_rdy steady -> req cycles 1-6, xfer/deq cycles 4-6, req=0 at cycle 7.
REQ-036 Same packet with out_rdy[2]=0 for 2 cycles mid-body -> req held, no xfer during the stall, tail still delivered, total 3 deq.
REQ-037 PORTID=0, multicast mdst=10110 -> requests to ports 1, 2, 4 in order; multab_ct 3, 2, 1; single deq with the port 4 xfer.
REQ-038 PORTID=1, multicast mdst=00010 -> deq=1, no req, no xfer, err=0.
REQ-039 Body flit at head while IDLE -> deq=1, err=1 for one cycle, no req.
REQ-040 rst_ low during USEND and during MSEND -> req, xfer, and deq drop immediately; after release, same buffer head restarts from IDLE.
